// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation encodings, FSM states and the step-mode selector.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  typedef enum logic {
    ModeMul,
    ModeDiv
  } mode_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier or the restoring
// divider. The accumulator holds {partial, multiplier} or {remainder, quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  mode_e              i_mode,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_next_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_trial;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    // A successful trial difference is always below the divisor, so WIDTH bits suffice.
    w_trial  = w_rem_sh[WIDTH-1:0] - i_operand;
    if (i_mode == ModeMul) begin
      o_next_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else if (w_rem_sh >= {1'b0, i_operand}) begin
      o_next_acc = {w_trial, i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_next_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU. Works on
// magnitudes one bit per cycle, then applies signs in a single fix-up cycle.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_hi,
  output logic [WIDTH-1:0] o_result_lo,
  output logic             o_div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             r_state;
  mode_e              r_mode;
  logic [CW-1:0]      r_counter;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_next_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mode    (r_mode),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_next_acc(w_next_acc)
  );

  always_comb begin
    w_signed = op_is_signed(i_op);
    w_abs_a  = (w_signed && i_data_a[WIDTH-1]) ? -i_data_a : i_data_a;
    w_abs_b  = (w_signed && i_data_b[WIDTH-1]) ? -i_data_b : i_data_b;
    // Sign flags are only ever set for signed ops, so unsigned results pass through.
    w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    w_quot   = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_mode    <= ModeMul;
      r_counter <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!i_flush && i_start) begin
            r_sign_a <= w_signed & i_data_a[WIDTH-1];
            r_sign_b <= w_signed & i_data_b[WIDTH-1];
            r_mode   <= op_is_div(i_op) ? ModeDiv : ModeMul;
            if (op_is_div(i_op) && (i_data_b == '0)) begin
              r_hi    <= i_data_a;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_state <= StDone;
            end else begin
              r_counter <= CW'(WIDTH - 1);
              r_acc     <= op_is_div(i_op) ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
              r_operand <= op_is_div(i_op) ? w_abs_b : w_abs_a;
              r_state   <= StCalc;
            end
          end
        end
        StCalc: begin
          if (i_flush) begin
            r_state <= StIdle;
          end else begin
            r_acc     <= w_next_acc;
            r_counter <= r_counter - 1'b1;
            if (r_counter == '0) r_state <= StFix;
          end
        end
        StFix: begin
          if (i_flush) begin
            r_state <= StIdle;
          end else begin
            if (r_mode == ModeDiv) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_dbz   <= 1'b0;
            r_state <= StDone;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_busy        = (r_state != StIdle);
    o_stall       = ((r_state == StIdle) && i_start) || (r_state == StCalc) || (r_state == StFix);
    o_done        = (r_state == StDone);
    o_result_hi   = r_hi;
    o_result_lo   = r_lo;
    o_div_by_zero = r_dbz;
  end

endmodule
